// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared alu32: arbitrates, registers the ALU operands and returns the captured result.
// Define ALU_ARB_ROUND_ROBIN_EN for alternating grants under contention; the default build uses fixed priority with req0 first.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_s,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_z,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [15:0]      ops_done
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           r_state;
    logic             r_lastGrant;
    logic             r_owner;
    logic [WIDTH-1:0] r_aluA;
    logic [WIDTH-1:0] r_aluB;
    logic [2:0]       r_aluS;
    logic [WIDTH-1:0] r_rspResult;
    logic             r_rspZero;
    logic             r_rsp0Valid;
    logic             r_rsp1Valid;
    logic [15:0]      r_opsDone;

    logic             w_grant;
    logic             w_canAccept;
    logic             w_handshake;
    logic [WIDTH-1:0] w_selA;
    logic [WIDTH-1:0] w_selB;
    logic [2:0]       w_selOp;

    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            w_grant = ~r_lastGrant;
`else
            w_grant = 1'b0;
`endif
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
    end

    // Readys are gated by rst_n because reset is synchronous and the state may still read EXEC/RESP.
    assign w_canAccept = rst_n && ((r_state == IDLE) || (r_state == RESP));
    assign req0_ready  = w_canAccept && !w_grant;
    assign req1_ready  = w_canAccept && w_grant;
    assign w_handshake = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign w_selA  = w_grant ? req1_a  : req0_a;
    assign w_selB  = w_grant ? req1_b  : req0_b;
    assign w_selOp = w_grant ? req1_op : req0_op;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_lastGrant <= 1'b1;
            r_owner     <= 1'b0;
            r_aluA      <= '0;
            r_aluB      <= '0;
            r_aluS      <= 3'b000;
            r_rspResult <= '0;
            r_rspZero   <= 1'b0;
            r_rsp0Valid <= 1'b0;
            r_rsp1Valid <= 1'b0;
            r_opsDone   <= 16'h0000;
        end else begin
            r_rsp0Valid <= 1'b0;
            r_rsp1Valid <= 1'b0;
            case (r_state)
                IDLE, RESP: begin
                    if (w_handshake) begin
                        r_aluA      <= w_selA;
                        r_aluB      <= w_selB;
                        r_aluS      <= w_selOp;
                        r_owner     <= w_grant;
                        r_lastGrant <= w_grant;
                        r_state     <= EXEC;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                EXEC: begin
                    // The pulse and count are registered here so they appear during RESP.
                    r_rspResult <= alu_r;
                    r_rspZero   <= alu_z;
                    if (r_owner) begin
                        r_rsp1Valid <= 1'b1;
                    end else begin
                        r_rsp0Valid <= 1'b1;
                    end
                    r_opsDone <= r_opsDone + 16'd1;
                    r_state   <= RESP;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign alu_a      = r_aluA;
    assign alu_b      = r_aluB;
    assign alu_s      = r_aluS;
    assign rsp_result = r_rspResult;
    assign rsp_zero   = r_rspZero;
    assign rsp0_valid = r_rsp0Valid;
    assign rsp1_valid = r_rsp1Valid;
    assign ops_done   = r_opsDone;

endmodule
